// File: rtl/iir_codec_tx.sv
// I2S-style mono transmitter: a one-entry holding buffer feeds a frame word that
// is serialised MSB-first into both slots. `define IIR_TX_SATURATE_EN to clamp instead of wrap.
module iir_codec_tx #(
    parameter int BCLK_DIV  = 4,
    parameter int DATA_BITS = 24,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
);

    localparam int CW = $clog2(BCLK_DIV);
    localparam int KW = $clog2(2 * SLOT_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(2 * SLOT_BITS - 1);
    localparam logic [KW-1:0] K_SLOT   = KW'(SLOT_BITS);
    localparam logic [KW-1:0] K_DATA   = KW'(DATA_BITS);
    localparam logic [KW-1:0] K_LR_LO  = KW'(SLOT_BITS - 1);
    localparam logic [KW-1:0] K_LR_HI  = KW'(2 * SLOT_BITS - 2);

    localparam logic [0:0] ST_WAIT_FIRST = 1'b0;
    localparam logic [0:0] ST_STREAM     = 1'b1;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 bclk_q, bclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 underrun_q, underrun_d;
    logic                 buf_full_q, buf_full_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic [DATA_BITS-1:0] frame_q, frame_d;
    logic [0:0]           state_q, state_d;

    logic [DATA_BITS-1:0] conv;
    logic [DATA_BITS-1:0] load_word;
    logic [DATA_BITS-1:0] word;
    logic [DATA_BITS-1:0] shifted;
    logic [KW-1:0]        j_slot;
    logic                 wrap, fall, frame_start, accept, bit_out;

`ifdef IIR_TX_SATURATE_EN
    localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (DATA_BITS - 1)) - 33'sd1;
    localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (DATA_BITS - 1));

    logic signed [32:0] s_ext;
    assign s_ext = {s_data[31], s_data};

    always_comb begin
        conv = s_data[DATA_BITS-1:0];
        if (s_ext > SAT_MAX) begin
            conv = SAT_MAX[DATA_BITS-1:0];
        end else if (s_ext < SAT_MIN) begin
            conv = SAT_MIN[DATA_BITS-1:0];
        end
    end
`else
    assign conv = s_data[DATA_BITS-1:0];

    if (DATA_BITS < 32) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^s_data[31:DATA_BITS];
    end
`endif

    assign wrap        = (cnt_q == CNT_LAST);
    assign fall        = wrap && bclk_q;
    assign frame_start = fall && (k_q == '0);
    assign accept      = s_valid && !buf_full_q;

    // frame_q keeps the word for the whole frame so the right slot replays it.
    assign load_word = buf_full_q ? buf_q : '0;
    assign word      = frame_start ? load_word : frame_q;
    assign j_slot    = (k_q >= K_SLOT) ? (k_q - K_SLOT) : k_q;
    assign shifted   = word << j_slot;
    assign bit_out   = (j_slot < K_DATA) ? shifted[DATA_BITS-1] : 1'b0;

    always_comb begin
        cnt_d      = wrap ? '0 : cnt_q + 1'b1;
        bclk_d     = wrap ? ~bclk_q : bclk_q;
        k_d        = k_q;
        sdata_d    = sdata_q;
        lrclk_d    = lrclk_q;
        frame_d    = frame_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        state_d    = state_q;
        underrun_d = frame_start && (state_q == ST_STREAM) && !buf_full_q;

        if (fall) begin
            k_d     = (k_q == K_LAST) ? '0 : k_q + 1'b1;
            sdata_d = bit_out;
            lrclk_d = (k_q >= K_LR_LO) && (k_q <= K_LR_HI);
        end
        if (frame_start) begin
            frame_d    = load_word;
            buf_full_d = 1'b0;
        end
        // A sample landing on a frame start with an empty buffer waits a frame.
        if (accept) begin
            buf_d      = conv;
            buf_full_d = 1'b1;
            state_d    = ST_STREAM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            k_q        <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            frame_q    <= '0;
            state_q    <= ST_WAIT_FIRST;
        end else begin
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            frame_q    <= frame_d;
            state_q    <= state_d;
        end
    end

    assign s_ready  = !buf_full_q;
    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_iir_codec_tx.sv
// Randomised bench for iir_codec_tx against a time-indexed frame model.
module tb_iir_codec_tx;

    localparam int DIV   = 2;
    localparam int DB    = 24;
    localparam int SB    = 32;
    localparam int PER   = 2 * DIV;
    localparam int FRAME = 2 * SB;
    localparam int FCYC  = FRAME * PER;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_ready, bclk, lrclk, sdata, underrun;

    always #5 clk = ~clk;

    iir_codec_tx #(.BCLK_DIV(DIV), .DATA_BITS(DB), .SLOT_BITS(SB)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int            c;
    logic [DB-1:0] mq[$];
    bit            streaming;
    logic [DB-1:0] cur;
    bit            exp_sd, exp_lr, last_acc;
    logic [DB-1:0] obs_l, obs_r;
    int            frames = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DB-1:0] conv(input logic [31:0] d);
`ifdef IIR_TX_SATURATE_EN
        int sd;
        sd = $signed(d);
        if (sd > (2 ** (DB - 1)) - 1) return {1'b0, {(DB-1){1'b1}}};
        if (sd < -(2 ** (DB - 1)))    return {1'b1, {(DB-1){1'b0}}};
        return d[DB-1:0];
`else
        return d[DB-1:0];
`endif
    endfunction

    function automatic bit is_fs(input int cc);
        return (cc > 0) && (cc % PER == 0) && (((cc / PER) - 1) % FRAME == 0);
    endfunction

    task automatic model_clear();
        c = 0;
        mq.delete();
        streaming = 1'b0;
        cur = '0;
        exp_sd = 1'b0;
        exp_lr = 1'b0;
        obs_l = '0;
        obs_r = '0;
    endtask

    // One clk of the DUT; outputs are sampled on the falling edge.
    task automatic tick();
        bit            in_v, rdy_before, str_before, fall, fs, exp_und;
        logic [31:0]   in_d;
        int            k, j;
        in_v = s_valid;
        in_d = s_data;
        rdy_before = (mq.size() == 0);
        str_before = streaming;
        @(posedge clk);
        @(negedge clk);
        c++;
        fall = (c % PER == 0);
        fs = 1'b0;
        exp_und = 1'b0;
        k = 0;
        if (fall) begin
            k = ((c / PER) - 1) % FRAME;
            fs = (k == 0);
        end
        if (fs) begin
            if (mq.size() > 0) begin
                cur = mq.pop_front();
            end else begin
                cur = '0;
                exp_und = str_before;
            end
        end
        last_acc = in_v && rdy_before;
        if (last_acc) begin
            mq.push_back(conv(in_d));
            streaming = 1'b1;
            $display("accept s_data=%h sent_as=%h", in_d, conv(in_d));
        end
        if (fall) begin
            j = k % SB;
            exp_sd = (j < DB) ? cur[DB-1-j] : 1'b0;
            exp_lr = (k >= SB - 1) && (k <= 2 * SB - 2);
        end
        check_eq("bclk",     32'(bclk),     32'((c / DIV) % 2));
        check_eq("underrun", 32'(underrun), 32'(exp_und));
        check_eq("s_ready",  32'(s_ready),  32'(mq.size() == 0));
        check_eq("sdata",    32'(sdata),    32'(exp_sd));
        check_eq("lrclk",    32'(lrclk),    32'(exp_lr));
        if (fall) begin
            if (k < DB) obs_l = {obs_l[DB-2:0], sdata};
            else if (k >= SB && k < SB + DB) obs_r = {obs_r[DB-2:0], sdata};
            if (k == FRAME - 1) begin
                $display("frame %0d: left=%h right=%h expected=%h", frames, obs_l, obs_r, cur);
                check_eq("left_word",  32'(obs_l), 32'(cur));
                check_eq("right_word", 32'(obs_r), 32'(cur));
                frames++;
            end
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data = d;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 2000);
        if (!last_acc) check_eq("send_timeout", 32'(last_acc), 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_bclk"},     32'(bclk),     32'd0);
        check_eq({tag, "_lrclk"},    32'(lrclk),    32'd0);
        check_eq({tag, "_sdata"},    32'(sdata),    32'd0);
        check_eq({tag, "_underrun"}, 32'(underrun), 32'd0);
        check_eq({tag, "_s_ready"},  32'(s_ready),  32'd1);
    endtask

    initial begin
        int n;
        model_clear();
        #23;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        // Idle before any sample: zero frames, no underrun.
        idle(2 * FCYC + 20);

        // Leave a sample buffered, then reset mid-frame while bclk is high.
        send(32'h0000_0ABC);
        n = 0;
        while (c % PER != DIV && n < 16) begin
            tick();
            n++;
        end
        check_eq("pre_reset_bclk", 32'(bclk), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("rst_now");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        reset = 1'b1;
        model_clear();

        // Basic frame then underrun frame.
        send(32'h0012_3456);
        idle(2 * FCYC);

        // Conversion cases, then three back-to-back samples.
        send(32'h0100_0000);
        send(32'hFF00_0000);
        send(32'h0065_4321);
        send(32'h00FE_DCBA);
        send(32'h0000_0001);
        idle(4 * FCYC);

        // Sample offered exactly on a frame start with an empty buffer.
        n = 0;
        while (!is_fs(c + 1) && n < 2 * FCYC) begin
            tick();
            n++;
        end
        check_eq("fs_align_buf_empty", 32'(mq.size()), 32'd0);
        s_valid = 1'b1;
        s_data = 32'h00AB_CDEF;
        tick();
        s_valid = 1'b0;
        idle(3 * FCYC);

        // Random traffic with occasional underruns and out-of-range samples.
        repeat (8 * FCYC) begin
            s_valid = ($urandom_range(0, 299) == 0);
            s_data = $urandom;
            tick();
        end
        idle(2 * FCYC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_codec_tx.md
IIR_CODEC_TX -- requirements
Module: iir_codec_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 4: clk cycles per bclk half-period; legal values are 2 or more.
REQ-002 SHALL have parameter DATA_BITS, default 24: number of audio bits sent per slot; legal range is 8 to 32.
REQ-003 SHALL have parameter SLOT_BITS, default 32: bclk periods per slot; SLOT_BITS SHALL be at least DATA_BITS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_data, input, 32 bits: signed filtered sample (filter y output).
REQ-007 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-008 SHALL have port s_ready, output, 1 bit: the holding buffer is empty; a transfer occurs on s_valid && s_ready.
REQ-009 SHALL have port bclk, output, 1 bit: codec bit clock.
REQ-010 SHALL have port lrclk, output, 1 bit: codec word select; 0 = left, 1 = right.
REQ-011 SHALL have port sdata, output, 1 bit: codec serial data.
REQ-012 SHALL have port underrun, output, 1 bit: one-clk pulse at a frame start when no sample is available.

Function
REQ-013 SHALL keep a divider counter 0..BCLK_DIV-1 and toggle the registered bclk when the counter wraps; bclk runs continuously out of reset.
REQ-014 SHALL define a "fall event" as the clk cycle in which bclk is driven 1->0, and SHALL advance a bit index k (0..2*SLOT_BITS-1, wrapping) on each fall event.
REQ-015 SHALL update sdata and lrclk only on fall events.
REQ-016 SHALL drive lrclk = 1 for k in [SLOT_BITS-1, 2*SLOT_BITS-2] and 0 otherwise, giving the I2S one-bit word-select lead.
REQ-017 SHALL treat k=0 as the frame start; at that fall event the shift register loads from the holding buffer and sdata presents the MSB of the converted sample.
REQ-018 SHALL send the converted sample MSB-first in the left slot (k=0..DATA_BITS-1), send zeros for the remaining slot bits, and repeat the identical sequence in the right slot (mono duplicated).
REQ-019 SHALL use a one-entry holding buffer: s_ready = buffer empty; an accepted sample sets it full; a frame-start load empties it.
REQ-020 SHALL not bypass the buffer: a sample accepted in the same cycle as a frame start with an empty buffer stays buffered for the next frame.
REQ-021 SHALL implement an FSM with states WAIT_FIRST and STREAM: reset enters WAIT_FIRST; the first accepted sample moves it to STREAM; there is no other exit except reset.
REQ-022 In WAIT_FIRST, SHALL transmit zero frames and never assert underrun.
REQ-023 In STREAM, at a frame start with the buffer empty, SHALL pulse underrun for exactly one clk and transmit a zero frame.
REQ-024 SHALL convert the sample to DATA_BITS bits according to REQ-029/REQ-030.

Reset
REQ-025 While reset = 0, SHALL hold bclk=0, lrclk=0, sdata=0, underrun=0, s_ready=1, with the buffer empty, all counters 0, and the FSM in WAIT_FIRST.
REQ-026 Reset asserted mid-frame SHALL take effect immediately; the partial frame and any buffered sample are discarded.
REQ-027 After reset deasserts, the first fall event SHALL occur 2*BCLK_DIV clk cycles later and SHALL be frame start k=0.

Configuration
REQ-028 Macro IIR_TX_SATURATE_EN SHALL select the conversion mode.
REQ-029 With IIR_TX_SATURATE_EN defined, s_data SHALL be clamped to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1] before being sent.
REQ-030 Without IIR_TX_SATURATE_EN, the module SHALL send s_data[DATA_BITS-1:0] unmodified (wrap), and SHALL contain no clamp logic.

Verification (BCLK_DIV=2, DATA_BITS=24, SLOT_BITS=32)
REQ-031 Reset check: pulse reset low mid-frame -> all outputs reset immediately, s_ready=1, first fall event 4 clks after release.
REQ-032 Basic frame: accept 0x00123456 before the first frame start -> left slot 0x123456 MSB-first plus 8 zeros; right slot identical; lrclk high for k=31..62.
REQ-033 Conversion: 0x01000000 -> 0x7FFFFF (macro defined) or 0x000000 (undefined); 0xFF000000 -> 0x800000 (macro defined) or 0x000000 (undefined).
REQ-034 Backpressure: offer 3 samples back-to-back -> the 1st is accepted, the 2nd is held with s_ready=0 until frame start, all 3 are sent in order, none are lost.
REQ-035 Underrun: one sample, then s_valid=0 -> the next frame start gives a one-clk underrun pulse and an all-zero frame; before the first sample, no underrun ever.
REQ-036 Simultaneous event: s_valid rises in the frame-start cycle with an empty buffer in STREAM -> underrun pulses, a zero frame is sent, and the sample goes out in the following frame.
